// File: rtl/md_poll_arb_pkg.sv
// md_poll_arb shared definitions: FSM encoding, engine control
// bit positions and the PHY status link bit index.
package md_poll_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WBSY,
    WRDY,
    DONE
  } md_state_e;

  localparam int CTRL_WE    = 6;
  localparam int CTRL_START = 5;
  localparam int LINK_BIT   = 2;

endpackage

// File: rtl/md_poll_tmr.sv
// md_poll_tmr: poll period down-counter.
// Ports: clk, rst_n (sync, active-low), en, due (1-cycle pulse).
module md_poll_tmr #(
  parameter logic [23:0] PERIOD = 24'd5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic due
);

  localparam logic [23:0] RELOAD = PERIOD - 24'd1;

  logic [23:0] cnt;

  assign due = en && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n || !en || due) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 24'd1;
    end
  end

endmodule

// File: rtl/md_poll_arb.sv
// md_poll_arb: arbitrates host PHY accesses and periodic status
// polls onto one MDIO engine. Ports: host slot (h_*), engine
// (md_*), poll enable/result (poll_*, link_*), wb_clk_i, wb_rst_n_i.
module md_poll_arb
  import md_poll_arb_pkg::*;
#(
  parameter logic [23:0] POLL_PERIOD = 24'd5_000_000,
  parameter logic [4:0]  POLL_ADDR   = 5'd1,
  parameter logic [15:0] TMO         = 16'd4095
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        h_req_i,
  input  logic        h_we_i,
  input  logic [4:0]  h_addr_i,
  input  logic [15:0] h_wdat_i,
  output logic        h_busy_o,
  output logic        h_done_o,
  output logic        h_err_o,
  output logic [15:0] h_rdat_o,
  input  logic        poll_en_i,
  output logic [6:0]  md_ctrl_o,
  output logic [15:0] md_wdat_o,
  input  logic [15:0] md_rdat_i,
  input  logic        md_rdy_i,
  output logic [15:0] poll_dat_o,
  output logic        link_o,
  output logic        link_chg_o
);

  localparam logic [15:0] TMO_M1 = TMO - 16'd1;

  md_state_e   state, state_n;
  logic        due, grant, pick_host, tmo_hit, h_acc;
  logic        busy_q, h_pend, h_we_q, poll_pend, rr_host;
  logic [4:0]  h_addr_q, op_addr;
  logic [15:0] h_wdat_q, op_wdat, wcnt;
  logic        op_poll, op_we, tmo_q;
  logic        h_err_q, link_chg_q;
  logic [15:0] h_rdat_q, poll_dat_q;

  md_poll_tmr #(.PERIOD(POLL_PERIOD)) u_tmr (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .en    (poll_en_i),
    .due   (due)
  );

  assign h_acc = h_req_i && !busy_q;

  always_comb begin
    state_n   = state;
    grant     = 1'b0;
    tmo_hit   = 1'b0;
    pick_host = h_pend && (!poll_pend || rr_host);
    unique case (state)
      IDLE: begin
        if (h_pend || poll_pend) begin
          grant   = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: state_n = WBSY;
      WBSY: begin
        if (!md_rdy_i) begin
          state_n = WRDY;
        end else if (wcnt == TMO_M1) begin
          tmo_hit = 1'b1;
          state_n = DONE;
        end
      end
      WRDY: begin
        if (md_rdy_i) begin
          state_n = DONE;
        end else if (wcnt == TMO_M1) begin
          tmo_hit = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      wcnt       <= '0;
      busy_q     <= 1'b0;
      h_pend     <= 1'b0;
      h_we_q     <= 1'b0;
      h_addr_q   <= '0;
      h_wdat_q   <= '0;
      poll_pend  <= 1'b0;
      rr_host    <= 1'b1;
      op_poll    <= 1'b0;
      op_we      <= 1'b0;
      op_addr    <= '0;
      op_wdat    <= '0;
      tmo_q      <= 1'b0;
      h_err_q    <= 1'b0;
      h_rdat_q   <= '0;
      poll_dat_q <= '0;
      link_chg_q <= 1'b0;
    end else begin
      // counter restarts on every state change, i.e. per wait state
      wcnt       <= (state_n != state) ? '0 : wcnt + 16'd1;
      tmo_q      <= tmo_hit;
      link_chg_q <= 1'b0;

      if (h_acc) begin
        busy_q   <= 1'b1;
        h_pend   <= 1'b1;
        h_we_q   <= h_we_i;
        h_addr_q <= h_addr_i;
        h_wdat_q <= h_wdat_i;
        h_err_q  <= 1'b0;
      end

      // slot frees as DONE is entered so busy is low with done
      if (state_n == DONE && !op_poll) begin
        busy_q <= 1'b0;
        if (tmo_hit) h_err_q <= 1'b1;
      end

      if (!poll_en_i) begin
        poll_pend <= 1'b0;
      end else if (due) begin
        poll_pend <= 1'b1;
      end else if (grant && !pick_host) begin
        poll_pend <= 1'b0;
      end

      if (grant) begin
        rr_host <= !pick_host;
        op_poll <= !pick_host;
        op_we   <= pick_host && h_we_q;
        op_addr <= pick_host ? h_addr_q : POLL_ADDR;
        op_wdat <= pick_host ? h_wdat_q : '0;
        if (pick_host) h_pend <= 1'b0;
      end

      if (state == DONE && !tmo_q) begin
        if (op_poll) begin
          poll_dat_q <= md_rdat_i;
          link_chg_q <= md_rdat_i[LINK_BIT] ^ poll_dat_q[LINK_BIT];
        end else if (!op_we) begin
          h_rdat_q <= md_rdat_i;
        end
      end
    end
  end

  always_comb begin
    md_ctrl_o             = '0;
    md_ctrl_o[4:0]        = op_addr;
    md_ctrl_o[CTRL_WE]    = op_we;
    md_ctrl_o[CTRL_START] = (state == ISSUE);
  end

  assign md_wdat_o  = op_wdat;
  assign h_busy_o   = busy_q;
  assign h_done_o   = (state == DONE) && !op_poll;
  assign h_err_o    = h_err_q;
  assign h_rdat_o   = h_rdat_q;
  assign poll_dat_o = poll_dat_q;
  assign link_o     = poll_dat_q[LINK_BIT];
  assign link_chg_o = link_chg_q;

endmodule

// File: tb/tb_md_poll_arb.sv
// md_poll_arb bench: behavioural MDIO engine plus per-feature
// scenario tasks checked against bench-side expectations.
module tb_md_poll_arb;

  localparam logic [23:0] PP = 24'd100;
  localparam logic [4:0]  PA = 5'd1;
  localparam logic [15:0] TM = 16'd50;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n_i, h_req_i, h_we_i, poll_en_i, md_rdy_i;
  logic [4:0]  h_addr_i;
  logic [15:0] h_wdat_i, md_rdat_i;
  logic        h_busy_o, h_done_o, h_err_o, link_o, link_chg_o;
  logic [15:0] h_rdat_o, md_wdat_o, poll_dat_o;
  logic [6:0]  md_ctrl_o;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [15:0] wdat;
    logic [15:0] rdat;
  } acc_t;

  acc_t        log_q[$];
  logic [15:0] dq[$];
  int          eng_busy = 4;
  bit          eng_stuck = 1'b0;
  int          n_start = 0;
  int          nvec = 0;
  int          nerr = 0;
  logic [15:0] exp_rdat = '0;
  logic [15:0] exp_poll = '0;

  md_poll_arb #(.POLL_PERIOD(PP), .POLL_ADDR(PA), .TMO(TM)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_n_i (wb_rst_n_i),
    .h_req_i    (h_req_i),
    .h_we_i     (h_we_i),
    .h_addr_i   (h_addr_i),
    .h_wdat_i   (h_wdat_i),
    .h_busy_o   (h_busy_o),
    .h_done_o   (h_done_o),
    .h_err_o    (h_err_o),
    .h_rdat_o   (h_rdat_o),
    .poll_en_i  (poll_en_i),
    .md_ctrl_o  (md_ctrl_o),
    .md_wdat_o  (md_wdat_o),
    .md_rdat_i  (md_rdat_i),
    .md_rdy_i   (md_rdy_i),
    .poll_dat_o (poll_dat_o),
    .link_o     (link_o),
    .link_chg_o (link_chg_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // engine: goes busy on start, ready again with data later
  initial begin : engine
    acc_t acc;
    md_rdy_i  = 1'b1;
    md_rdat_i = '0;
    forever begin
      @(negedge wb_clk_i);
      if (md_ctrl_o[5] === 1'b1 && wb_rst_n_i === 1'b1) begin
        acc.we   = md_ctrl_o[6];
        acc.addr = md_ctrl_o[4:0];
        acc.wdat = md_wdat_o;
        acc.rdat = (dq.size() > 0) ? dq.pop_front() : 16'($urandom);
        log_q.push_back(acc);
        n_start++;
        if (eng_stuck) begin
          md_rdat_i = acc.rdat;
        end else begin
          md_rdy_i = 1'b0;
          repeat (eng_busy) @(negedge wb_clk_i);
          md_rdat_i = acc.rdat;
          md_rdy_i  = 1'b1;
        end
      end
    end
  end

  task automatic do_reset();
    wb_rst_n_i = 1'b0;
    h_req_i    = 1'b0;
    poll_en_i  = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
    @(negedge wb_clk_i);
    log_q.delete();
    dq.delete();
    exp_rdat = '0;
    exp_poll = '0;
  endtask

  task automatic issue(input logic we, input logic [4:0] a,
                       input logic [15:0] d);
    int n;
    n = 0;
    while (h_busy_o !== 1'b0 && n < 300) begin
      @(negedge wb_clk_i);
      n++;
    end
    if (n >= 300) begin
      nvec++;
      nerr++;
      $display("FAIL issue_wait: h_busy_o=%b required 0", h_busy_o);
    end
    h_req_i  = 1'b1;
    h_we_i   = we;
    h_addr_i = a;
    h_wdat_i = d;
    @(negedge wb_clk_i);
    h_req_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [59:0] o;
    wb_rst_n_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    o = {md_ctrl_o, md_wdat_o, h_busy_o, h_done_o, h_err_o,
         h_rdat_o, poll_dat_o, link_o, link_chg_o};
    nvec++;
    if (o !== 60'd0) begin
      nerr++;
      $display("FAIL rst_hold: outputs=%h required 0", o);
    end
    wb_rst_n_i = 1'b1;
    @(negedge wb_clk_i);
    o = {md_ctrl_o, md_wdat_o, h_busy_o, h_done_o, h_err_o,
         h_rdat_o, poll_dat_o, link_o, link_chg_o};
    nvec++;
    if (o !== 60'd0) begin
      nerr++;
      $display("FAIL rst_rel: outputs=%h required 0", o);
    end
  endtask

  task automatic test_host_read(input logic [4:0] a,
                                input logic [15:0] d, input int b);
    int st0, nd, ns;
    eng_busy = b;
    dq.push_back(d);
    st0 = n_start;
    issue(1'b0, a, 16'($urandom));
    nvec++;
    if (h_busy_o !== 1'b1 || h_err_o !== 1'b0) begin
      nerr++;
      $display("FAIL rd_accept: busy=%b err=%b required 1 0",
               h_busy_o, h_err_o);
    end
    nd = 0;
    ns = 0;
    for (int c = 0; c < 40 + b; c++) begin
      if (md_ctrl_o[5] === 1'b1) begin
        ns++;
        nvec++;
        if (md_ctrl_o !== {2'b01, a}) begin
          nerr++;
          $display("FAIL rd_ctrl: md_ctrl_o=%b required %b",
                   md_ctrl_o, {2'b01, a});
        end
      end
      if (h_done_o === 1'b1) begin
        nd++;
        nvec++;
        if (h_busy_o !== 1'b0) begin
          nerr++;
          $display("FAIL rd_busy_at_done: busy=%b required 0", h_busy_o);
        end
      end
      @(negedge wb_clk_i);
    end
    nvec++;
    if (ns != 1 || n_start - st0 != 1) begin
      nerr++;
      $display("FAIL rd_start: pulses=%0d required 1", ns);
    end
    nvec++;
    if (nd != 1) begin
      nerr++;
      $display("FAIL rd_done: pulses=%0d required 1", nd);
    end
    nvec++;
    if (h_rdat_o !== d) begin
      nerr++;
      $display("FAIL rd_data: h_rdat_o=%h required %h", h_rdat_o, d);
    end
    exp_rdat = d;
  endtask

  task automatic test_host_write(input logic [4:0] a,
                                 input logic [15:0] d);
    int nd, bad;
    bit inop;
    nd = 0;
    bad = 0;
    inop = 1'b0;
    eng_busy = 6;
    issue(1'b1, a, d);
    for (int c = 0; c < 60; c++) begin
      if (md_ctrl_o[5] === 1'b1) begin
        inop = 1'b1;
        nvec++;
        if (md_ctrl_o !== {2'b11, a}) begin
          nerr++;
          $display("FAIL wr_ctrl: md_ctrl_o=%b required %b",
                   md_ctrl_o, {2'b11, a});
        end
      end
      if (inop && (md_ctrl_o[6] !== 1'b1 || md_wdat_o !== d)) bad++;
      if (h_done_o === 1'b1) begin
        nd++;
        inop = 1'b0;
      end
      @(negedge wb_clk_i);
    end
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL wr_hold: bad_cycles=%0d required 0", bad);
    end
    nvec++;
    if (nd != 1) begin
      nerr++;
      $display("FAIL wr_done: pulses=%0d required 1", nd);
    end
    nvec++;
    if (h_rdat_o !== exp_rdat) begin
      nerr++;
      $display("FAIL wr_rdat: h_rdat_o=%h required %h", h_rdat_o, exp_rdat);
    end
  endtask

  task automatic test_poll_link();
    int nchg, rise, fall, tail, bad;
    logic prev;
    log_q.delete();
    dq.push_back(16'h0004);
    dq.push_back(16'h0000);
    eng_busy = 3;
    nchg = 0;
    rise = 0;
    fall = 0;
    tail = 0;
    prev = exp_poll[2];
    poll_en_i = 1'b1;
    for (int c = 0; c < 600 && tail < 20; c++) begin
      @(negedge wb_clk_i);
      if (link_chg_o === 1'b1) nchg++;
      if (link_o !== prev) begin
        if (link_o === 1'b1) rise++;
        else fall++;
      end
      prev = link_o;
      if (log_q.size() >= 2) tail++;
    end
    poll_en_i = 1'b0;
    bad = 0;
    foreach (log_q[i]) if (log_q[i].we || log_q[i].addr != PA) bad++;
    nvec++;
    if (log_q.size() != 2 || bad != 0) begin
      nerr++;
      $display("FAIL poll_access: count=%0d bad=%0d required 2 0",
               log_q.size(), bad);
    end
    nvec++;
    if (nchg != 2) begin
      nerr++;
      $display("FAIL link_chg: pulses=%0d required 2", nchg);
    end
    nvec++;
    if (rise != 1 || fall != 1) begin
      nerr++;
      $display("FAIL link_seq: rise=%0d fall=%0d required 1 1", rise, fall);
    end
    nvec++;
    if (poll_dat_o !== 16'h0000) begin
      nerr++;
      $display("FAIL poll_dat: poll_dat_o=%h required 0000", poll_dat_o);
    end
    exp_poll = 16'h0000;
  endtask

  task automatic test_timeout();
    int ts, td, n0, nchg;
    eng_stuck = 1'b1;
    dq.push_back(16'hBEEF);
    issue(1'b0, 5'd5, 16'h0);
    ts = -1;
    td = -1;
    for (int c = 0; c < 150 && td < 0; c++) begin
      if (md_ctrl_o[5] === 1'b1 && ts < 0) ts = c;
      if (h_done_o === 1'b1) begin
        td = c;
        nvec++;
        if (h_err_o !== 1'b1) begin
          nerr++;
          $display("FAIL tmo_err: h_err_o=%b required 1", h_err_o);
        end
      end
      @(negedge wb_clk_i);
    end
    nvec++;
    if (ts < 0 || td - ts != 51) begin
      nerr++;
      $display("FAIL tmo_lat: start=%0d done=%0d required gap 51", ts, td);
    end
    nvec++;
    if (h_rdat_o !== exp_rdat) begin
      nerr++;
      $display("FAIL tmo_rdat: h_rdat_o=%h required %h", h_rdat_o, exp_rdat);
    end
    // poll timeout must leave the status register alone
    dq.push_back(16'hFFFF);
    n0 = n_start;
    nchg = 0;
    poll_en_i = 1'b1;
    for (int c = 0; c < 300 && n_start == n0; c++) @(negedge wb_clk_i);
    for (int c = 0; c < 60; c++) begin
      if (link_chg_o === 1'b1) nchg++;
      @(negedge wb_clk_i);
    end
    poll_en_i = 1'b0;
    nvec++;
    if (n_start == n0 || poll_dat_o !== exp_poll || nchg != 0) begin
      nerr++;
      $display("FAIL poll_tmo: polls=%0d poll_dat_o=%h chg=%0d required 1 %h 0",
               n_start - n0, poll_dat_o, nchg, exp_poll);
    end
    eng_stuck = 1'b0;
    repeat (5) @(negedge wb_clk_i);
  endtask

  task automatic test_reset_mid();
    logic [59:0] o;
    int n0, nd, ns;
    eng_busy = 30;
    dq.push_back(16'h5A5A);
    n0 = n_start;
    issue(1'b0, 5'd9, 16'h0);
    for (int c = 0; c < 20 && n_start == n0; c++) @(negedge wb_clk_i);
    repeat (10) @(negedge wb_clk_i);
    wb_rst_n_i = 1'b0;
    @(negedge wb_clk_i);
    o = {md_ctrl_o, md_wdat_o, h_busy_o, h_done_o, h_err_o,
         h_rdat_o, poll_dat_o, link_o, link_chg_o};
    nvec++;
    if (n_start == n0 || md_rdy_i !== 1'b0 || o !== 60'd0) begin
      nerr++;
      $display("FAIL rst_mid: started=%0d rdy=%b outputs=%h required 1 0 0",
               n_start - n0, md_rdy_i, o);
    end
    wb_rst_n_i = 1'b1;
    nd = 0;
    ns = 0;
    for (int c = 0; c < 40; c++) begin
      if (h_done_o === 1'b1) nd++;
      if (md_ctrl_o[5] === 1'b1) ns++;
      @(negedge wb_clk_i);
    end
    nvec++;
    if (nd != 0 || ns != 0) begin
      nerr++;
      $display("FAIL rst_abort: done=%0d start=%0d required 0 0", nd, ns);
    end
    exp_rdat = '0;
    exp_poll = '0;
  endtask

  task automatic test_rr();
    do_reset();
    eng_busy = 3;
    poll_en_i = 1'b1;
    repeat (99) @(negedge wb_clk_i);
    // lands in the same cycle the poll timer expires
    h_req_i  = 1'b1;
    h_we_i   = 1'b0;
    h_addr_i = 5'd7;
    h_wdat_i = '0;
    @(negedge wb_clk_i);
    h_req_i = 1'b0;
    for (int c = 0; c < 1000 && log_q.size() < 6; c++) begin
      if (h_busy_o === 1'b0) h_req_i = 1'b1;
      @(negedge wb_clk_i);
      h_req_i = 1'b0;
    end
    poll_en_i = 1'b0;
    nvec++;
    if (log_q.size() < 3) begin
      nerr++;
      $display("FAIL rr_count: grants=%0d required >=3", log_q.size());
    end else if (log_q[0].addr != 5'd7 || log_q[1].addr != PA ||
                 log_q[2].addr != 5'd7) begin
      nerr++;
      $display("FAIL rr_order: addrs=%0d,%0d,%0d required 7,%0d,7",
               log_q[0].addr, log_q[1].addr, log_q[2].addr, PA);
    end
    repeat (30) @(negedge wb_clk_i);
    foreach (log_q[i]) begin
      if (log_q[i].addr == PA) exp_poll = log_q[i].rdat;
      else exp_rdat = log_q[i].rdat;
    end
  endtask

  task automatic test_random();
    logic        we;
    logic [4:0]  a;
    logic [15:0] d;
    int          td, hi;
    poll_en_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      we = 1'($urandom_range(0, 1));
      a  = 5'($urandom_range(8, 31));
      d  = 16'($urandom);
      eng_busy = $urandom_range(2, 40);
      issue(we, a, d);
      td = -1;
      for (int c = 0; c < 300 && td < 0; c++) begin
        if (h_done_o === 1'b1) td = c;
        @(negedge wb_clk_i);
      end
      hi = -1;
      foreach (log_q[i]) if (log_q[i].addr >= 5'd8) hi = i;
      nvec++;
      if (td < 0 || hi < 0) begin
        nerr++;
        $display("FAIL rnd_done: access %0d never completed", k);
      end else begin
        if (log_q[hi].we != we || log_q[hi].addr != a ||
            (we && log_q[hi].wdat != d)) begin
          nerr++;
          $display("FAIL rnd_engine: we=%b addr=%0d wdat=%h required %b %0d %h",
                   log_q[hi].we, log_q[hi].addr, log_q[hi].wdat, we, a, d);
        end
        if (!we) exp_rdat = log_q[hi].rdat;
      end
      nvec++;
      if (h_rdat_o !== exp_rdat) begin
        nerr++;
        $display("FAIL rnd_rdat: h_rdat_o=%h required %h", h_rdat_o, exp_rdat);
      end
    end
    poll_en_i = 1'b0;
    repeat (60) @(negedge wb_clk_i);
    foreach (log_q[i]) if (log_q[i].addr == PA) exp_poll = log_q[i].rdat;
    nvec++;
    if (poll_dat_o !== exp_poll) begin
      nerr++;
      $display("FAIL rnd_poll: poll_dat_o=%h required %h", poll_dat_o, exp_poll);
    end
  endtask

  initial begin
    wb_rst_n_i = 1'b0;
    h_req_i    = 1'b0;
    h_we_i     = 1'b0;
    h_addr_i   = '0;
    h_wdat_i   = '0;
    poll_en_i  = 1'b0;
    @(negedge wb_clk_i);
    test_reset();
    test_host_read(5'd3, 16'h1234, 20);
    test_host_write(5'd0, 16'h8000);
    for (int k = 0; k < 3; k++) begin
      test_host_read(5'($urandom), 16'($urandom), $urandom_range(2, 40));
    end
    test_poll_link();
    test_timeout();
    test_host_read(5'd4, 16'hC3A5, 5);
    test_reset_mid();
    test_rr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
